// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, functs, states,
// datapath select codes and the decoded-instruction payload.
package mc_ctrl_pkg;

    localparam int unsigned OPW    = 6;
    localparam int unsigned ALUOPW = 3;
    localparam int unsigned STW    = 3;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_BLTZ  = 6'b000001;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;
    localparam logic [OPW-1:0] OP_JAL   = 6'b000011;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPW-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_HALT  = 6'b111111;

    localparam logic [OPW-1:0] FN_SLL = 6'b000000;
    localparam logic [OPW-1:0] FN_JR  = 6'b001000;
    localparam logic [OPW-1:0] FN_ADD = 6'b100000;
    localparam logic [OPW-1:0] FN_SUB = 6'b100010;
    localparam logic [OPW-1:0] FN_AND = 6'b100100;
    localparam logic [OPW-1:0] FN_OR  = 6'b100101;
    localparam logic [OPW-1:0] FN_SLT = 6'b101010;

    typedef enum logic [STW-1:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b111
    } state_t;

    // ALU_SLL is an extension code beyond the five arithmetic/logic ops.
    localparam logic [ALUOPW-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUOPW-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUOPW-1:0] ALU_AND = 3'b010;
    localparam logic [ALUOPW-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUOPW-1:0] ALU_SLT = 3'b100;
    localparam logic [ALUOPW-1:0] ALU_SLL = 3'b101;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_RS  = 2'd2;
    localparam logic [1:0] PC_JMP = 2'd3;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    // Sub-kind within a class: jump 0=j 1=jal 2=jr; branch 0=beq 1=bne 2=bltz;
    // rtype 1=sll; itype 1=zero-extended immediate.
    localparam logic [1:0] SUB_0 = 2'd0;
    localparam logic [1:0] SUB_1 = 2'd1;
    localparam logic [1:0] SUB_2 = 2'd2;

    typedef struct packed {
        logic rtype;
        logic itype;
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic halt;
        logic illegal;
    } cls_t;

    typedef struct packed {
        cls_t              cls;
        logic [1:0]        sub;
        logic [ALUOPW-1:0] alu_op;
    } dec_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct decoder: instruction class one-hot, sub-kind and ALU op.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [OPW-1:0] i_opcode,
    input  logic [OPW-1:0] i_funct,
    output dec_t           o_dec
);

    always_comb begin
        o_dec        = '0;
        o_dec.alu_op = ALU_ADD;
        case (i_opcode)
            OP_RTYPE: begin
                o_dec.cls.rtype = 1'b1;
                case (i_funct)
                    FN_ADD: o_dec.alu_op = ALU_ADD;
                    FN_SUB: o_dec.alu_op = ALU_SUB;
                    FN_AND: o_dec.alu_op = ALU_AND;
                    FN_OR:  o_dec.alu_op = ALU_OR;
                    FN_SLT: o_dec.alu_op = ALU_SLT;
                    FN_SLL: begin
                        o_dec.alu_op = ALU_SLL;
                        o_dec.sub    = SUB_1;
                    end
                    FN_JR: begin
                        o_dec.cls.rtype = 1'b0;
                        o_dec.cls.jump  = 1'b1;
                        o_dec.sub       = SUB_2;
                    end
                    default: begin
                        o_dec.cls.rtype   = 1'b0;
                        o_dec.cls.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI: o_dec.cls.itype = 1'b1;
            OP_ORI: begin
                o_dec.cls.itype = 1'b1;
                o_dec.alu_op    = ALU_OR;
                o_dec.sub       = SUB_1;
            end
            OP_SLTI: begin
                o_dec.cls.itype = 1'b1;
                o_dec.alu_op    = ALU_SLT;
            end
            OP_LW:  o_dec.cls.load  = 1'b1;
            OP_SW:  o_dec.cls.store = 1'b1;
            OP_BEQ: begin
                o_dec.cls.branch = 1'b1;
                o_dec.alu_op     = ALU_SUB;
            end
            OP_BNE: begin
                o_dec.cls.branch = 1'b1;
                o_dec.alu_op     = ALU_SUB;
                o_dec.sub        = SUB_1;
            end
            OP_BLTZ: begin
                o_dec.cls.branch = 1'b1;
                o_dec.alu_op     = ALU_SUB;
                o_dec.sub        = SUB_2;
            end
            OP_J:    o_dec.cls.jump = 1'b1;
            OP_JAL: begin
                o_dec.cls.jump = 1'b1;
                o_dec.sub      = SUB_1;
            end
            OP_HALT: o_dec.cls.halt    = 1'b1;
            default: o_dec.cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control FSM (IF/ID/EXE/MEM/WB/HALT).
// ILLEGAL_OP_TRAP_EN: illegal instructions trap to HALT and raise illop.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
(
    input  logic              CLK,
    input  logic              Rst,
    input  logic [OPW-1:0]    opcode,
    input  logic [OPW-1:0]    funct,
    input  logic              zero,
    input  logic              sign,
    output logic              PCWre,
    output logic [1:0]        PCSrc,
    output logic              IRWre,
    output logic [ALUOPW-1:0] ALUOp,
    output logic              ALUSrcA,
    output logic              ALUSrcB,
    output logic              ExtSel,
    output logic              RegWre,
    output logic [1:0]        RegDst,
    output logic              WrRegDSrc,
    output logic              DBDataSrc,
    output logic              mRD,
    output logic              mWR,
    output logic [STW-1:0]    state,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic              illop,
`endif
    output logic              halted
);

    state_t r_state;
    state_t w_next;
    dec_t   w_dec;
    logic   w_taken;

    mc_ctrl_decode u_decode (
        .i_opcode (opcode),
        .i_funct  (funct),
        .o_dec    (w_dec)
    );

    always_ff @(posedge CLK) begin
        if (Rst) r_state <= S_IF;
        else     r_state <= w_next;
    end

    assign state = r_state;

`ifdef ILLEGAL_OP_TRAP_EN
    logic r_illop;

    // Sticky trap flag; only reset clears it.
    always_ff @(posedge CLK) begin
        if (Rst)                                     r_illop <= 1'b0;
        else if (r_state == S_ID && w_dec.cls.illegal) r_illop <= 1'b1;
    end

    assign illop = r_illop & ~Rst;
`endif

    always_comb begin
        case (w_dec.sub)
            SUB_0:   w_taken = zero;
            SUB_1:   w_taken = ~zero;
            SUB_2:   w_taken = sign;
            default: w_taken = 1'b0;
        endcase
    end

    // Next state and Moore/Mealy controls; everything idles at 0 under reset.
    always_comb begin
        w_next    = r_state;
        PCWre     = 1'b0;
        PCSrc     = PC_SEQ;
        IRWre     = 1'b0;
        ALUOp     = ALU_ADD;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        RegWre    = 1'b0;
        RegDst    = RD_RT;
        WrRegDSrc = 1'b0;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        halted    = 1'b0;
        if (Rst) begin
            w_next = S_IF;
        end else begin
            case (r_state)
                S_IF: begin
                    IRWre  = 1'b1;
                    w_next = S_ID;
                end
                S_ID: begin
                    if (w_dec.cls.jump) begin
                        PCWre  = 1'b1;
                        PCSrc  = (w_dec.sub == SUB_2) ? PC_RS : PC_JMP;
                        if (w_dec.sub == SUB_1) begin
                            RegWre = 1'b1;
                            RegDst = RD_RA;
                        end
                        w_next = S_IF;
                    end else if (w_dec.cls.halt) begin
                        w_next = S_HALT;
                    end else if (w_dec.cls.illegal) begin
`ifdef ILLEGAL_OP_TRAP_EN
                        w_next = S_HALT;
`else
                        PCWre  = 1'b1;
                        w_next = S_IF;
`endif
                    end else begin
                        w_next = S_EXE;
                    end
                end
                S_EXE: begin
                    ALUOp = w_dec.alu_op;
                    if (w_dec.cls.rtype) begin
                        ALUSrcA = (w_dec.sub == SUB_1);
                        w_next  = S_WB;
                    end else if (w_dec.cls.itype) begin
                        ALUSrcB = 1'b1;
                        ExtSel  = (w_dec.sub != SUB_1);
                        w_next  = S_WB;
                    end else if (w_dec.cls.load || w_dec.cls.store) begin
                        ALUSrcB = 1'b1;
                        ExtSel  = 1'b1;
                        w_next  = S_MEM;
                    end else if (w_dec.cls.branch) begin
                        PCWre  = 1'b1;
                        PCSrc  = w_taken ? PC_BR : PC_SEQ;
                        w_next = S_IF;
                    end else begin
                        w_next = S_IF;
                    end
                end
                S_MEM: begin
                    if (w_dec.cls.load) begin
                        mRD    = 1'b1;
                        w_next = S_WB;
                    end else begin
                        mWR    = 1'b1;
                        PCWre  = 1'b1;
                        w_next = S_IF;
                    end
                end
                S_WB: begin
                    RegWre    = 1'b1;
                    RegDst    = w_dec.cls.rtype ? RD_RD : RD_RT;
                    WrRegDSrc = 1'b1;
                    DBDataSrc = w_dec.cls.load;
                    PCWre     = 1'b1;
                    w_next    = S_IF;
                end
                S_HALT: begin
                    halted = 1'b1;
                    w_next = S_HALT;
                end
                default: w_next = S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: stimulus pushes per-cycle expected control
// vectors, a negedge monitor pops and compares them.
module tb_mc_ctrl_fsm;

    typedef logic [21:0] vec_t;

    logic       CLK = 1'b0;
    logic       Rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       sign = 1'b0;
    logic       PCWre, IRWre, ALUSrcA, ALUSrcB, ExtSel, RegWre;
    logic       WrRegDSrc, DBDataSrc, mRD, mWR, halted, w_illop;
    logic [1:0] PCSrc, RegDst;
    logic [2:0] ALUOp, state;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t q[$];

    always #5 CLK = ~CLK;

    mc_ctrl_fsm dut (
        .CLK(CLK), .Rst(Rst), .opcode(opcode), .funct(funct), .zero(zero), .sign(sign),
        .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .RegWre(RegWre), .RegDst(RegDst),
        .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR), .state(state),
`ifdef ILLEGAL_OP_TRAP_EN
        .illop(w_illop),
`endif
        .halted(halted)
    );
`ifndef ILLEGAL_OP_TRAP_EN
    assign w_illop = 1'b0;
`endif

    // alu = {ALUOp,ALUSrcA,ALUSrcB,ExtSel}; rf = {RegWre,RegDst,WrRegDSrc,DBDataSrc}; mem = {mRD,mWR}
    function automatic vec_t ex(input logic [2:0] st, input logic pcw, input logic [1:0] pcs,
                                input logic irw, input logic [5:0] alu, input logic [4:0] rf,
                                input logic [1:0] mem, input logic hlt, input logic il);
        return {st, pcw, pcs, irw, alu, rf, mem, hlt, il};
    endfunction

    function automatic vec_t only_st(input logic [2:0] st);
        return ex(st, 1'b0, 2'd0, 1'b0, 6'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    endfunction

    task automatic step(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic s, input vec_t e);
        @(posedge CLK);
        #1;
        Rst = rst; opcode = op; funct = fn; zero = z; sign = s;
        q.push_back(e);
    endtask

    task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
        step(1'b0, op, fn, 1'b1, 1'b1, ex(3'd0, 1'b0, 2'd0, 1'b1, 6'd0, 5'd0, 2'd0, 1'b0, 1'b0));
    endtask

    // Four-cycle ALU instruction; flags toggled outside EXE must be ignored.
    task automatic alu4(input logic [5:0] op, input logic [5:0] fn, input logic [5:0] alu,
                        input logic [4:0] rf);
        fetch(op, fn);
        step(1'b0, op, fn, 1'b1, 1'b0, only_st(3'd1));
        step(1'b0, op, fn, 1'b0, 1'b1, ex(3'd2, 1'b0, 2'd0, 1'b0, alu, 5'd0, 2'd0, 1'b0, 1'b0));
        step(1'b0, op, fn, 1'b1, 1'b1, ex(3'd4, 1'b1, 2'd0, 1'b0, 6'd0, rf, 2'd0, 1'b0, 1'b0));
    endtask

    task automatic branch(input logic [5:0] op, input logic z, input logic s, input logic [1:0] pcs);
        fetch(op, 6'd0);
        step(1'b0, op, 6'd0, ~z, ~s, only_st(3'd1));
        step(1'b0, op, 6'd0, z, s, ex(3'd2, 1'b1, pcs, 1'b0, 6'b001_000, 5'd0, 2'd0, 1'b0, 1'b0));
    endtask

    task automatic jump(input logic [5:0] op, input logic [5:0] fn, input logic [1:0] pcs,
                        input logic [4:0] rf);
        fetch(op, fn);
        step(1'b0, op, fn, 1'b0, 1'b0, ex(3'd1, 1'b1, pcs, 1'b0, 6'd0, rf, 2'd0, 1'b0, 1'b0));
    endtask

    task automatic illegal(input logic [5:0] op, input logic [5:0] fn);
        fetch(op, fn);
`ifdef ILLEGAL_OP_TRAP_EN
        step(1'b0, op, fn, 1'b0, 1'b0, only_st(3'd1));
        step(1'b0, op, fn, 1'b0, 1'b0, ex(3'd7, 1'b0, 2'd0, 1'b0, 6'd0, 5'd0, 2'd0, 1'b1, 1'b1));
        step(1'b0, op, fn, 1'b0, 1'b0, ex(3'd7, 1'b0, 2'd0, 1'b0, 6'd0, 5'd0, 2'd0, 1'b1, 1'b1));
        step(1'b1, op, fn, 1'b0, 1'b0, only_st(3'd7));
`else
        step(1'b0, op, fn, 1'b0, 1'b0, ex(3'd1, 1'b1, 2'd0, 1'b0, 6'd0, 5'd0, 2'd0, 1'b0, 1'b0));
`endif
    endtask

    // Monitor: the control vector is meaningful every cycle.
    initial begin
        vec_t e, a;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {state, PCWre, PCSrc, IRWre, ALUOp, ALUSrcA, ALUSrcB, ExtSel, RegWre, RegDst,
                     WrRegDSrc, DBDataSrc, mRD, mWR, halted, w_illop};
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL vec%0d @%0t: got %b required %b (st|pcw|pcs|irw|aluop|sa|sb|ext|rw|rd|wrs|dbs|mrd|mwr|hlt|il)",
                             n_vec, $time, a, e);
                end
            end
        end
    end

    initial begin
        step(1'b1, 6'd0, 6'd0, 1'b0, 1'b0, only_st(3'd0));
        step(1'b1, 6'd0, 6'd0, 1'b0, 1'b0, only_st(3'd0));
        alu4(6'b000000, 6'b100000, 6'b000_000, 5'b1_01_1_0);   // add
        fetch(6'b100011, 6'd0);                                // lw
        step(1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, only_st(3'd1));
        step(1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, ex(3'd2, 1'b0, 2'd0, 1'b0, 6'b000_011, 5'd0, 2'd0, 1'b0, 1'b0));
        step(1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, ex(3'd3, 1'b0, 2'd0, 1'b0, 6'd0, 5'd0, 2'b10, 1'b0, 1'b0));
        step(1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, ex(3'd4, 1'b1, 2'd0, 1'b0, 6'd0, 5'b1_00_1_1, 2'd0, 1'b0, 1'b0));
        fetch(6'b101011, 6'd0);                                // sw
        step(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, only_st(3'd1));
        step(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, ex(3'd2, 1'b0, 2'd0, 1'b0, 6'b000_011, 5'd0, 2'd0, 1'b0, 1'b0));
        step(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, ex(3'd3, 1'b1, 2'd0, 1'b0, 6'd0, 5'd0, 2'b01, 1'b0, 1'b0));
        branch(6'b000100, 1'b1, 1'b0, 2'd1);                   // beq taken
        branch(6'b000100, 1'b0, 1'b0, 2'd0);                   // beq not taken
        branch(6'b000001, 1'b0, 1'b1, 2'd1);                   // bltz taken
        branch(6'b000101, 1'b0, 1'b0, 2'd1);                   // bne taken
        branch(6'b000101, 1'b1, 1'b0, 2'd0);                   // bne not taken
        jump(6'b000011, 6'd0, 2'd3, 5'b1_10_0_0);              // jal
        jump(6'b000000, 6'b001000, 2'd2, 5'd0);                // jr
        jump(6'b000010, 6'd0, 2'd3, 5'd0);                     // j
        alu4(6'b000000, 6'b100010, 6'b001_000, 5'b1_01_1_0);   // sub
        alu4(6'b000000, 6'b101010, 6'b100_000, 5'b1_01_1_0);   // slt
        alu4(6'b000000, 6'b000000, 6'b101_100, 5'b1_01_1_0);   // sll
        alu4(6'b001000, 6'd0, 6'b000_011, 5'b1_00_1_0);        // addi
        alu4(6'b001101, 6'd0, 6'b011_010, 5'b1_00_1_0);        // ori
        alu4(6'b001010, 6'd0, 6'b100_011, 5'b1_00_1_0);        // slti
        illegal(6'b110011, 6'd0);
        illegal(6'b000000, 6'b111111);
        fetch(6'b100011, 6'd0);                                // reset mid-instruction
        step(1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, only_st(3'd1));
        step(1'b1, 6'b100011, 6'd0, 1'b0, 1'b0, only_st(3'd2));
        fetch(6'b111111, 6'd0);                                // halt
        step(1'b0, 6'b111111, 6'd0, 1'b0, 1'b0, only_st(3'd1));
        for (int i = 0; i < 10; i++)
            step(1'b0, 6'b111111, 6'd0, 1'b1, 1'b1, ex(3'd7, 1'b0, 2'd0, 1'b0, 6'd0, 5'd0, 2'd0, 1'b1, 1'b0));
        step(1'b1, 6'b111111, 6'd0, 1'b0, 1'b0, only_st(3'd7));
        alu4(6'b000000, 6'b100101, 6'b011_000, 5'b1_01_1_0);   // or after release
        alu4(6'b000000, 6'b100100, 6'b010_000, 5'b1_01_1_0);   // and
        @(posedge CLK);
        @(posedge CLK);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d vectors left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
